// File: rtl/key_debounce_ctrl.sv
// Key front end: 2-flop synchronisers, per-key debounce, wrapping mode code
// and hold-to-repeat step pulses for the frequency and phase buttons.
module key_debounce_ctrl #(
  parameter int unsigned DEB_CNT = 1_000_000,
  parameter int unsigned REP_DLY = 25_000_000,
  parameter int unsigned REP_PER = 5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_mode_n,
  input  logic       key_fre_n,
  input  logic       key_pha_n,
  output logic [1:0] mode_key,
  output logic       fre_adjust,
  output logic       pha_adjust
);

  localparam int unsigned NK   = 3;  // 0: mode, 1: fre, 2: pha
  localparam int unsigned NA   = 2;  // adjust channels: 0: fre, 1: pha
  localparam int unsigned DW   = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned HMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REP_DLY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REP_PER - 1);

  logic [NK-1:0] key_raw;
  logic [NK-1:0] sync1_q;
  logic [NK-1:0] key_s_q;
  logic [NK-1:0] stable_q, stable_d;
  logic [NK-1:0] stable_d1_q;
  logic [NK-1:0] press;
  logic [DW-1:0] deb_cnt_q [NK];
  logic [DW-1:0] deb_cnt_d [NK];

  logic [HW-1:0] hold_cnt_q [NA];
  logic [HW-1:0] hold_cnt_d [NA];
  logic [NA-1:0] rep_q, rep_d;
  logic [NA-1:0] pulse_q, pulse_d;
  logic [1:0]    mode_q, mode_d;

  assign key_raw = {key_pha_n, key_fre_n, key_mode_n};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      key_s_q <= '1;
    end else begin
      sync1_q <= key_raw;
      key_s_q <= sync1_q;
    end
  end

  // A level is accepted only after DEB_CNT consecutive cycles of disagreement.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned k = 0; k < NK; k++) begin
      deb_cnt_d[k] = '0;
      if (key_s_q[k] != stable_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          stable_d[k] = key_s_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable_q    <= '1;
      stable_d1_q <= '1;
      for (int unsigned k = 0; k < NK; k++) begin
        deb_cnt_q[k] <= '0;
      end
    end else begin
      stable_q    <= stable_d;
      stable_d1_q <= stable_q;
      for (int unsigned k = 0; k < NK; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
      end
    end
  end

  assign press = stable_d1_q & ~stable_q;

  // rep_q selects the repeat period once the initial delay has elapsed; a repeat
  // landing on the edge where stable rises is dropped via stable_d.
  always_comb begin
    rep_d   = rep_q;
    pulse_d = '0;
    for (int unsigned j = 0; j < NA; j++) begin
      hold_cnt_d[j] = hold_cnt_q[j];
      if (press[j+1]) begin
        pulse_d[j]    = 1'b1;
        hold_cnt_d[j] = '0;
        rep_d[j]      = 1'b0;
      end else if (stable_q[j+1]) begin
        hold_cnt_d[j] = '0;
        rep_d[j]      = 1'b0;
      end else if (hold_cnt_q[j] == (rep_q[j] ? PER_LAST : DLY_LAST)) begin
        pulse_d[j]    = ~stable_d[j+1];
        hold_cnt_d[j] = '0;
        rep_d[j]      = 1'b1;
      end else begin
        hold_cnt_d[j] = hold_cnt_q[j] + HW'(1);
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (press[0]) begin
      mode_d = mode_q + 2'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rep_q   <= '0;
      pulse_q <= '0;
      mode_q  <= 2'b01;
      for (int unsigned j = 0; j < NA; j++) begin
        hold_cnt_q[j] <= '0;
      end
    end else begin
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
      for (int unsigned j = 0; j < NA; j++) begin
        hold_cnt_q[j] <= hold_cnt_d[j];
      end
    end
  end

  assign mode_key   = mode_q;
  assign fre_adjust = pulse_q[0];
  assign pha_adjust = pulse_q[1];

endmodule
